// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, fixed 34-cycle latency per op.
// Define ALU_MULDIV_DIV_EN to build the divider; otherwise divide ops return 0.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] aluA,
    input  logic [XLEN-1:0] aluB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;
    state_t            r_state, w_next;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a, r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [4:0]        r_cnt;
    logic              r_neg;
    logic              w_div, w_a_sgn, w_b_sgn;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_p;
    logic [XLEN-1:0]   w_res;
`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN:0]     w_rs;
    logic [XLEN+1:0]   w_diff;
    logic [XLEN-1:0]   w_d, w_dn;
`endif

    assign busy    = r_state != IDLE;
    assign w_div   = r_op[2];
    // Sign flags read the raw latched operands, before PREP replaces them with magnitudes
    assign w_a_sgn = r_a[XLEN-1] & (r_op == 3'b001 || r_op == 3'b010 || r_op == 3'b100 || r_op == 3'b110);
    assign w_b_sgn = r_b[XLEN-1] & (r_op == 3'b001 || r_op == 3'b100 || r_op == 3'b110);
    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_p     = r_neg ? -r_acc : r_acc;
`ifdef ALU_MULDIV_DIV_EN
    assign w_rs    = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    assign w_diff  = {1'b0, w_rs} - {2'b00, r_b};
    assign w_d     = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_dn    = r_neg ? -w_d : w_d;
    assign w_res   = w_div ? w_dn : (r_op[1:0] == 2'b00 ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN]);
`else
    assign w_res   = w_div ? '0 : (r_op[1:0] == 2'b00 ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? PREP : IDLE;
            PREP:    w_next = CALC;
            CALC:    w_next = (r_cnt == 5'd31) ? FIN : CALC;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= r_state == FIN;
            if (r_state == IDLE && start) begin
                r_op <= op;
                r_a  <= aluA;
                r_b  <= aluB;
            end
            if (r_state == PREP) begin
                r_a   <= w_a_sgn ? -r_a : r_a;
                r_b   <= w_b_sgn ? -r_b : r_b;
                r_acc <= '0;
                r_cnt <= '0;
                // A zero divisor keeps the all-ones quotient un-negated; REM follows the dividend
                r_neg <= (r_op == 3'b110) ? w_a_sgn : (w_a_sgn ^ w_b_sgn) & (!w_div || r_b != '0);
            end
            if (r_state == CALC) begin
                r_cnt <= r_cnt + 5'd1;
                if (!w_div) begin
                    r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    r_b   <= r_b >> 1;
                end
`ifdef ALU_MULDIV_DIV_EN
                else begin
                    r_acc <= w_diff[XLEN+1] ? {w_rs[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                            : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                    r_a   <= r_a << 1;
                end
`endif
            end
            if (r_state == FIN) result <= w_res;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed + random scoreboard bench for alu_muldiv.
// Divide expectations follow ALU_MULDIV_DIV_EN (zero when the divider is not built).
module tb_alu_muldiv;
`ifdef ALU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] aluA = '0, aluB = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [31:0] q[$];
    int          n_checks = 0, n_fail = 0, cyc = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .aluA(aluA), .aluB(aluB),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dv(input logic [31:0] x);
        return DIV_EN ? x : 32'd0;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p   = '0;
        r   = '0;
        case (o)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return o[2] ? dv(r) : r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        q.push_back(exp);
        op = o; aluA = a; aluB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; aluA = $urandom; aluB = $urandom;
        cyc = 0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        logic bz;
        logic [31:0] exp;
        bz = 1'b1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!done) bz &= busy;
        end
        exp = (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx;
        check({tag, "_latency"}, cyc, 34);
        check({tag, "_busy_held"}, {31'd0, bz}, 32'd1);
        check({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, result, exp);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        launch(o, a, b, exp);
        wait_done(tag);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          pulses;
        #3;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("mul",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("div",    3'b100, 32'hFFFFFFF9, 32'h00000002, dv(32'hFFFFFFFD));
        run("rem",    3'b110, 32'hFFFFFFF9, 32'h00000002, dv(32'hFFFFFFFF));
        run("divu",   3'b101, 32'hFFFFFFF9, 32'h00000002, dv(32'h7FFFFFFC));
        run("div_by0",  3'b100, 32'h12345678, 32'h00000000, dv(32'hFFFFFFFF));
        run("remu_by0", 3'b111, 32'h12345678, 32'h00000000, dv(32'h12345678));
        run("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, dv(32'h80000000));
        run("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, dv(32'h00000000));
        run("div_10_2", 3'b100, 32'd10, 32'd2, dv(32'd5));
        run("mul_10_2", 3'b000, 32'd10, 32'd2, 32'h00000014);

        // start while busy is ignored, then a start in the done cycle is accepted
        @(negedge clk);
        launch(3'b000, 32'd3, 32'd5, 32'h0000000F);
        repeat (9) begin @(posedge clk); #1; cyc++; end
        start = 1'b1; op = 3'b000; aluA = 32'd7; aluB = 32'd9;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        wait_done("ignore_start");
        launch(3'b000, 32'd2, 32'd2, 32'h00000004);
        check("b2b_done_dropped", {31'd0, done}, 32'd0);
        wait_done("b2b");
        @(posedge clk); #1;
        check("b2b_done_one_cycle", {31'd0, done}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run("random", ro, ra, rb, model(ro, ra, rb));
        end

        // reset mid-operation aborts with no done
        @(negedge clk);
        launch(3'b100, 32'd100, 32'd7, 32'd0);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(q.pop_front());
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        check("abort_no_done", pulses, 0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
